merlin_imem_rsp: RTL and testbench
==================================

Name: merlin_imem_rsp

Overview:
Instruction-bus responder: the target end of the prefetch unit's ireq/irsp interface.
- Accepts word-aligned fetch requests and reads a local synchronous instruction RAM.
- Returns data in order after a fixed, parameterised latency, with bounded response buffering.
- Flags bus errors for out-of-range addresses.
- Sits between the core's PFU and the instruction memory in simulation and FPGA builds.
- A side load port fills the RAM before or while the core runs.

Parameters:
C_MEM_DEPTH_X, 10, log2 of RAM depth in 32-bit words (default 4 KiB).
C_READ_LATENCY, 1, cycles from request acceptance to data in response buffer; legal 1..4.
C_RSP_DEPTH_X, 2, log2 of response buffer depth; depth must be >= C_READ_LATENCY + 1.

Ports:
clk_i  in  1  clock
resetb_i  in  1  asynchronous active-low reset
clk_en_i  in  1  clock enable; when low, all state holds and no handshake completes
ireqready_o  out  1  responder can accept a request
ireqvalid_i  in  1  request valid
ireqhpl_i  in  2  requester privilege level (0=U, 3=M)
ireqaddr_i  in  RV_XLEN  byte address; bits [1:0] ignored
irspready_i  in  1  requester accepts response
irspvalid_o  out  1  response valid
irsprerr_o  out  1  response is a bus error
irspdata_o  out  RV_XLEN  instruction word
ldvalid_i  in  1  RAM load write strobe
ldaddr_i  in  C_MEM_DEPTH_X  load word address
lddata_i  in  32  load data

Behaviour:
- Clocking and reset:
  - Single clock. Reset is asynchronous, active-low, on resetb_i.
  - All registers except the RAM array advance only when clk_en_i=1.
- Reset values:
  - irspvalid_o=0, irsprerr_o=0, irspdata_o=0, ireqready_o=1.
  - Outstanding count=0; pipeline valids=0; buffer empty.
  - RAM contents are not reset.
- Accept and pop:
  - Accept = ireqvalid_i & ireqready_o & clk_en_i.
  - Pop = irspvalid_o & irspready_i & clk_en_i.
- Outstanding counter (C_RSP_DEPTH_X+1 bits), covering requests in the pipeline plus entries in the buffer:
  - +1 on accept only; -1 on pop only.
  - Accept and pop in the same cycle: unchanged.
  - ireqready_o = (count < 2**C_RSP_DEPTH_X), combinational from the count register only. No dependence on ireqvalid_i.
  - The buffer can never overflow; the full condition back-pressures via ireqready_o.
- Addressing:
  - Word index = ireqaddr_i[C_MEM_DEPTH_X+1:2].
  - Range error if any of ireqaddr_i[RV_XLEN-1:C_MEM_DEPTH_X+2] is nonzero.
- Read pipeline:
  - Shift register of C_READ_LATENCY stages, each carrying {valid, rerr}.
  - The RAM read issues at accept.
  - Data and rerr are written into the buffer on the edge ending cycle N+C_READ_LATENCY, where N is the accept cycle.
  - irspvalid_o is asserted from cycle N+C_READ_LATENCY onward.
  - With L=1, a response is valid the cycle after acceptance, and back-to-back accepts give back-to-back responses.
- Errored response: irsprerr_o=1 and irspdata_o=0.
- Response buffer:
  - Circular FIFO of 2**C_RSP_DEPTH_X entries, {rerr, data}.
  - irspvalid_o = not empty; irspdata_o and irsprerr_o reflect the head entry.
  - Head values are held stable while irspvalid_o=1 and irspready_i=0.
  - Push and pop in the same cycle are both honoured; pointers wrap modulo depth.
  - When the buffer is empty, outputs keep their last value (0 after reset).
- Ordering: responses are strictly in request order. There is no flush input; the requester discards stale responses.
- Load port:
  - The RAM is written on the edge when ldvalid_i=1, independent of clk_en_i.
  - Load and read of the same word in the same cycle: the read returns the old data.
- Reset mid-operation: in-flight requests and buffered responses are dropped; the block returns to reset values immediately.
- ireqhpl_i is ignored unless the optional feature is compiled in.

Optional Feature:
MERLIN_IMEM_PRIV_CHECK_EN
- When defined:
  - Parameter C_PRIV_BOUNDARY (default 32'h0000_0400) is added.
  - A request with ireqhpl_i==0 and ireqaddr_i < C_PRIV_BOUNDARY completes as an error response (irsprerr_o=1, data 0), with the same latency and ordering.
  - The error reason is OR'd with the range error.
- When undefined: the parameter is absent, ireqhpl_i is unused, and only range errors are reported.

Test Plan:
- Reset, L=1: load word 0=32'h0000_0013, word 1=32'h0010_0093; request addr 0 then 4 on consecutive cycles with irspready_i=1 -> irspvalid_o high on the 2 following cycles with data 13h, 100093h, rerr=0.
- Back-pressure, depth 4: hold irspready_i=0 and issue 6 requests -> exactly 4 accepted, ireqready_o=0 after the 4th; release ready -> 4 responses in order, then ireqready_o returns to 1.
- Range error, C_MEM_DEPTH_X=10: request addr 32'h0000_1000 -> response with rerr=1, data 0; next request addr 8 -> normal data, rerr=0.
- Simultaneous: with count=4 (full), a pop and a new request in the same cycle -> request not accepted that cycle (ready=0); next cycle ready=1 and it is accepted.
- Async reset mid-flight: assert resetb_i low while 2 requests are outstanding -> irspvalid_o drops immediately; after release no stale response appears and ireqready_o=1.
- With MERLIN_IMEM_PRIV_CHECK_EN: hpl=0 at addr 32'h100 -> rerr=1; hpl=3 at the same addr -> loaded data, rerr=0.

Source files
------------

// File: rtl/merlin_imem_rsp_if.sv
// merlin_imem_rsp_if: instruction fetch request/response bus between the
// prefetch unit (master) and the instruction memory responder (slave).
interface merlin_imem_rsp_if #(
    parameter int RV_XLEN = 32
);
    logic               ireqready_o;
    logic               ireqvalid_i;
    logic [1:0]         ireqhpl_i;
    logic [RV_XLEN-1:0] ireqaddr_i;
    logic               irspready_i;
    logic               irspvalid_o;
    logic               irsprerr_o;
    logic [RV_XLEN-1:0] irspdata_o;

    modport master (
        input  ireqready_o, irspvalid_o, irsprerr_o, irspdata_o,
        output ireqvalid_i, ireqhpl_i, ireqaddr_i, irspready_i
    );

    modport slave (
        output ireqready_o, irspvalid_o, irsprerr_o, irspdata_o,
        input  ireqvalid_i, ireqhpl_i, ireqaddr_i, irspready_i
    );
endinterface

// File: rtl/merlin_imem_rsp.sv
// merlin_imem_rsp: target end of the PFU instruction bus. Reads a local
// synchronous RAM, returns in-order responses after C_READ_LATENCY cycles
// through a small response FIFO, and flags out-of-range fetches as errors.
// A side load port writes the RAM at any time.
// Optional feature macro: MERLIN_IMEM_PRIV_CHECK_EN (user-mode fetches below
// C_PRIV_BOUNDARY return an error response).
module merlin_imem_rsp #(
    parameter int RV_XLEN        = 32,
    parameter int C_MEM_DEPTH_X  = 10,
    parameter int C_READ_LATENCY = 1,
    parameter int C_RSP_DEPTH_X  = 2
`ifdef MERLIN_IMEM_PRIV_CHECK_EN
    ,
    parameter logic [RV_XLEN-1:0] C_PRIV_BOUNDARY = RV_XLEN'(32'h0000_0400)
`endif
) (
    input  logic                     clk_i,
    input  logic                     resetb_i,
    input  logic                     clk_en_i,
    merlin_imem_rsp_if.slave         bus,
    input  logic                     ldvalid_i,
    input  logic [C_MEM_DEPTH_X-1:0] ldaddr_i,
    input  logic [31:0]              lddata_i
);

    localparam int RSP_DEPTH = 1 << C_RSP_DEPTH_X;
    localparam int CNT_W     = C_RSP_DEPTH_X + 1;
    localparam int PTR_W     = C_RSP_DEPTH_X;
    localparam int LAT       = C_READ_LATENCY;
    localparam int MEM_WORDS = 1 << C_MEM_DEPTH_X;

    logic [31:0]              mem [MEM_WORDS];

    logic [CNT_W-1:0]         out_cnt;
    logic                     req_rdy;
    logic                     accept;
    logic                     pop;
    logic                     push;
    logic                     buf_pop;
    logic                     buf_empty;
    logic                     rsp_vld;
    logic [C_MEM_DEPTH_X-1:0] widx;
    logic                     range_err;
    logic                     req_err;
    logic                     unused_ok;

    logic [LAT-1:0]           vld_p;
    logic [LAT-1:0]           rerr_p;
    logic [31:0]              data_p [LAT];
    logic                     lst_vld;
    logic                     lst_rerr;
    logic [31:0]              lst_data;

    logic [31:0]              fifo_data [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]     fifo_rerr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         fill;

    logic [31:0]              hold_data;
    logic                     hold_rerr;
    logic [31:0]              head_data;
    logic                     head_rerr;

    assign widx      = bus.ireqaddr_i[C_MEM_DEPTH_X+1:2];
    assign range_err = |bus.ireqaddr_i[RV_XLEN-1:C_MEM_DEPTH_X+2];

`ifdef MERLIN_IMEM_PRIV_CHECK_EN
    assign req_err   = range_err |
                       ((bus.ireqhpl_i == 2'd0) && (bus.ireqaddr_i < C_PRIV_BOUNDARY));
    assign unused_ok = ^bus.ireqaddr_i[1:0];
`else
    assign req_err   = range_err;
    assign unused_ok = ^{bus.ireqaddr_i[1:0], bus.ireqhpl_i};
`endif

    // Requests in flight plus buffered responses never exceed the FIFO depth,
    // so the FIFO cannot overflow and ready depends on the count register only.
    assign req_rdy = (out_cnt < CNT_W'(RSP_DEPTH));
    assign accept  = bus.ireqvalid_i & req_rdy & clk_en_i;

    // The last pipeline stage is presented directly when the FIFO is empty,
    // which gives a one-cycle response at C_READ_LATENCY=1.
    assign lst_vld   = vld_p[LAT-1];
    assign lst_rerr  = rerr_p[LAT-1];
    assign lst_data  = lst_rerr ? 32'd0 : data_p[LAT-1];

    assign buf_empty = (fill == '0);
    assign rsp_vld   = ~buf_empty | lst_vld;
    assign pop       = rsp_vld & bus.irspready_i & clk_en_i;
    assign buf_pop   = pop & ~buf_empty;
    assign push      = lst_vld & clk_en_i & ~(pop & buf_empty);

    // Select the head: oldest FIFO entry, else the bypassed stage, else last value.
    always_comb begin
        head_data = hold_data;
        head_rerr = hold_rerr;
        if (!buf_empty) begin
            head_data = fifo_data[rd_ptr];
            head_rerr = fifo_rerr[rd_ptr];
        end else if (lst_vld) begin
            head_data = lst_data;
            head_rerr = lst_rerr;
        end
    end

    assign bus.ireqready_o = req_rdy;
    assign bus.irspvalid_o = rsp_vld;
    assign bus.irsprerr_o  = head_rerr;
    assign bus.irspdata_o  = RV_XLEN'(head_data);

    // Side load port writes the RAM regardless of clock enable.
    always_ff @(posedge clk_i) begin
        if (ldvalid_i) begin
            mem[ldaddr_i] <= lddata_i;
        end
    end

    // Synchronous RAM read at accept, then data delay stages (old data on collision).
    always_ff @(posedge clk_i) begin
        if (clk_en_i) begin
            if (accept) begin
                data_p[0] <= mem[widx];
            end
            for (int k = 1; k < LAT; k++) begin
                data_p[k] <= data_p[k-1];
            end
        end
    end

    // Valid/error shift register tracking each accepted request.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            vld_p  <= '0;
            rerr_p <= '0;
        end else if (clk_en_i) begin
            vld_p[0]  <= accept;
            rerr_p[0] <= req_err;
            for (int k = 1; k < LAT; k++) begin
                vld_p[k]  <= vld_p[k-1];
                rerr_p[k] <= rerr_p[k-1];
            end
        end
    end

    // Outstanding count: accepted requests not yet popped.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            out_cnt <= '0;
        end else if (clk_en_i) begin
            if (accept && !pop) begin
                out_cnt <= out_cnt + CNT_W'(1);
            end else if (pop && !accept) begin
                out_cnt <= out_cnt - CNT_W'(1);
            end
        end
    end

    // FIFO storage write of the completed pipeline stage.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr] <= lst_data;
            fifo_rerr[wr_ptr] <= lst_rerr;
        end
    end

    // FIFO pointers and fill level; pointers wrap modulo the depth.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (buf_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !buf_pop) begin
                fill <= fill + CNT_W'(1);
            end else if (buf_pop && !push) begin
                fill <= fill - CNT_W'(1);
            end
        end
    end

    // Remember the last delivered response so outputs hold it while idle.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            hold_data <= '0;
            hold_rerr <= 1'b0;
        end else if (pop) begin
            hold_data <= head_data;
            hold_rerr <= head_rerr;
        end
    end

endmodule

// File: tb/tb_merlin_imem_rsp.sv
// tb_merlin_imem_rsp: randomized and directed bench for merlin_imem_rsp with a
// transaction-level reference (queue of outstanding responses, shadow RAM).
module tb_merlin_imem_rsp;
    localparam int XLEN  = 32;
    localparam int MEM_X = 10;
    localparam int LAT   = 1;
    localparam int RSP_X = 2;
    localparam int DEPTH = 1 << RSP_X;

    logic             clk = 1'b0;
    logic             resetb = 1'b0;
    logic             clk_en = 1'b1;
    logic             ldvalid = 1'b0;
    logic [MEM_X-1:0] ldaddr = '0;
    logic [31:0]      lddata = '0;

    merlin_imem_rsp_if #(.RV_XLEN(XLEN)) bus();

    merlin_imem_rsp #(
        .RV_XLEN(XLEN), .C_MEM_DEPTH_X(MEM_X),
        .C_READ_LATENCY(LAT), .C_RSP_DEPTH_X(RSP_X)
    ) dut (
        .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en), .bus(bus),
        .ldvalid_i(ldvalid), .ldaddr_i(ldaddr), .lddata_i(lddata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        rerr;
        logic [31:0] data;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mem_m [1 << MEM_X];
    int          en_cnt = 0;
    logic [31:0] hold_d = '0;
    logic        hold_e = 1'b0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic exp_ready();
        return q.size() < DEPTH;
    endfunction

    function automatic logic exp_valid();
        if (q.size() == 0) return 1'b0;
        return q[0].due <= en_cnt;
    endfunction

    function automatic logic [31:0] exp_data();
        return exp_valid() ? q[0].data : hold_d;
    endfunction

    function automatic logic exp_rerr();
        return exp_valid() ? q[0].rerr : hold_e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, input logic [1:0] h,
                         input logic r, input logic ce);
        bus.ireqvalid_i = v;
        bus.ireqaddr_i  = a;
        bus.ireqhpl_i   = h;
        bus.irspready_i = r;
        clk_en          = ce;
    endtask

    // Advance the reference by one clock using the currently driven inputs.
    task automatic tick();
        logic acc, pp, err;
        rsp_t e;
        acc = bus.ireqvalid_i && exp_ready() && clk_en;
        pp  = exp_valid() && bus.irspready_i && clk_en;
        if (pp) begin
            hold_d = q[0].data;
            hold_e = q[0].rerr;
            void'(q.pop_front());
        end
        if (acc) begin
            err = (bus.ireqaddr_i >= (32'd1 << (MEM_X + 2)));
`ifdef MERLIN_IMEM_PRIV_CHECK_EN
            if (bus.ireqhpl_i == 2'd0 && bus.ireqaddr_i < 32'h0000_0400) err = 1'b1;
`endif
            e.due  = en_cnt + LAT;
            e.rerr = err;
            e.data = err ? 32'd0 : mem_m[bus.ireqaddr_i[MEM_X+1:2]];
            q.push_back(e);
        end
        if (clk_en) en_cnt++;
        if (ldvalid) mem_m[ldaddr] = lddata;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'd0, 2'd3, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.irspvalid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.irspvalid_o); end
        checks++; if (bus.ireqready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ireqready_o); end
        checks++; if (bus.irsprerr_o !== 1'b0) begin errors++; $display("FAIL reset_rerr got=%b exp=0", bus.irsprerr_o); end
        checks++; if (bus.irspdata_o !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.irspdata_o); end
        resetb = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < (1 << MEM_X); i++) begin
            ldvalid = 1'b1;
            ldaddr  = MEM_X'(i);
            lddata  = $urandom;
            @(negedge clk);
            tick();
        end
        ldvalid = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] words [2];
        logic        vt [5];
        logic [31:0] at [5];
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        for (int i = 0; i < 2; i++) begin
            ldvalid = 1'b1; ldaddr = MEM_X'(i); lddata = words[i];
            @(negedge clk);
            tick();
        end
        ldvalid = 1'b0;
        vt = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        at = '{32'd0, 32'd4, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 5; i++) begin
            drive(vt[i], at[i], 2'd3, 1'b1, 1'b1);
            @(negedge clk);
            checks++; if (bus.ireqready_o !== exp_ready()) begin errors++; $display("FAIL basic_ready cyc=%0d got=%b exp=%b", i, bus.ireqready_o, exp_ready()); end
            checks++; if (bus.irspvalid_o !== exp_valid()) begin errors++; $display("FAIL basic_valid cyc=%0d got=%b exp=%b", i, bus.irspvalid_o, exp_valid()); end
            checks++; if ({bus.irsprerr_o, bus.irspdata_o} !== {exp_rerr(), exp_data()}) begin errors++; $display("FAIL basic_head cyc=%0d got=%b/%h exp=%b/%h", i, bus.irsprerr_o, bus.irspdata_o, exp_rerr(), exp_data()); end
            if (i == 1 || i == 2) begin
                checks++;
                if ({bus.irspvalid_o, bus.irsprerr_o, bus.irspdata_o} !== {1'b1, 1'b0, words[i-1]}) begin
                    errors++; $display("FAIL basic_const cyc=%0d got=%b/%b/%h exp=1/0/%h", i, bus.irspvalid_o, bus.irsprerr_o, bus.irspdata_o, words[i-1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        int n_pop = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 6) drive(1'b1, 32'(i * 4), 2'd3, 1'b0, 1'b1);
            else       drive(1'b0, 32'd0, 2'd3, 1'b1, 1'b1);
            @(negedge clk);
            checks++; if (bus.ireqready_o !== exp_ready()) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", i, bus.ireqready_o, exp_ready()); end
            checks++; if (bus.irspvalid_o !== exp_valid()) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", i, bus.irspvalid_o, exp_valid()); end
            checks++; if ({bus.irsprerr_o, bus.irspdata_o} !== {exp_rerr(), exp_data()}) begin errors++; $display("FAIL bp_head cyc=%0d got=%b/%h exp=%b/%h", i, bus.irsprerr_o, bus.irspdata_o, exp_rerr(), exp_data()); end
            if (i < 6 && bus.ireqready_o === 1'b1) n_acc++;
            if (i >= 6 && bus.irspvalid_o === 1'b1) n_pop++;
            tick();
        end
        checks++; if (n_acc !== 4) begin errors++; $display("FAIL bp_accepts got=%0d exp=4", n_acc); end
        checks++; if (n_pop !== 4) begin errors++; $display("FAIL bp_pops got=%0d exp=4", n_pop); end
        checks++; if (bus.ireqready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_after got=%b exp=1", bus.ireqready_o); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 12; i++) begin
            if (i < 4)       drive(1'b1, 32'(16 + i * 4), 2'd3, 1'b0, 1'b1);
            else if (i == 4) drive(1'b1, 32'h40, 2'd3, 1'b1, 1'b1);
            else if (i == 5) drive(1'b1, 32'h40, 2'd3, 1'b0, 1'b1);
            else             drive(1'b0, 32'd0, 2'd3, 1'b1, 1'b1);
            @(negedge clk);
            checks++; if (bus.ireqready_o !== exp_ready()) begin errors++; $display("FAIL sim_ready cyc=%0d got=%b exp=%b", i, bus.ireqready_o, exp_ready()); end
            checks++; if (bus.irspvalid_o !== exp_valid()) begin errors++; $display("FAIL sim_valid cyc=%0d got=%b exp=%b", i, bus.irspvalid_o, exp_valid()); end
            checks++; if ({bus.irsprerr_o, bus.irspdata_o} !== {exp_rerr(), exp_data()}) begin errors++; $display("FAIL sim_head cyc=%0d got=%b/%h exp=%b/%h", i, bus.irsprerr_o, bus.irspdata_o, exp_rerr(), exp_data()); end
            if (i == 4) begin checks++; if (bus.ireqready_o !== 1'b0) begin errors++; $display("FAIL sim_full_ready got=%b exp=0", bus.ireqready_o); end end
            if (i == 5) begin checks++; if (bus.ireqready_o !== 1'b1) begin errors++; $display("FAIL sim_next_ready got=%b exp=1", bus.ireqready_o); end end
            tick();
        end
    endtask

    task automatic test_range();
        logic        vt [4];
        logic [31:0] at [4];
        vt = '{1'b1, 1'b1, 1'b0, 1'b0};
        at = '{32'h0000_1000, 32'd8, 32'd0, 32'd0};
        for (int i = 0; i < 4; i++) begin
            drive(vt[i], at[i], 2'd3, 1'b1, 1'b1);
            @(negedge clk);
            checks++; if (bus.irspvalid_o !== exp_valid()) begin errors++; $display("FAIL range_valid cyc=%0d got=%b exp=%b", i, bus.irspvalid_o, exp_valid()); end
            checks++; if ({bus.irsprerr_o, bus.irspdata_o} !== {exp_rerr(), exp_data()}) begin errors++; $display("FAIL range_head cyc=%0d got=%b/%h exp=%b/%h", i, bus.irsprerr_o, bus.irspdata_o, exp_rerr(), exp_data()); end
            if (i == 1) begin checks++; if ({bus.irspvalid_o, bus.irsprerr_o, bus.irspdata_o} !== {1'b1, 1'b1, 32'd0}) begin errors++; $display("FAIL range_err got=%b/%b/%h exp=1/1/0", bus.irspvalid_o, bus.irsprerr_o, bus.irspdata_o); end end
            if (i == 2) begin checks++; if ({bus.irspvalid_o, bus.irsprerr_o, bus.irspdata_o} !== {1'b1, 1'b0, mem_m[2]}) begin errors++; $display("FAIL range_ok got=%b/%b/%h exp=1/0/%h", bus.irspvalid_o, bus.irsprerr_o, bus.irspdata_o, mem_m[2]); end end
            tick();
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_1000;
            else a = {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom)};
            drive(1'($urandom), a, 2'($urandom), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 8));
            ldvalid = ($urandom_range(0, 4) == 0);
            ldaddr  = ($urandom_range(0, 1) == 1) ? a[MEM_X+1:2] : MEM_X'($urandom);
            lddata  = $urandom;
            @(negedge clk);
            checks++; if (bus.ireqready_o !== exp_ready()) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, bus.ireqready_o, exp_ready()); end
            checks++; if (bus.irspvalid_o !== exp_valid()) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, bus.irspvalid_o, exp_valid()); end
            checks++; if ({bus.irsprerr_o, bus.irspdata_o} !== {exp_rerr(), exp_data()}) begin errors++; $display("FAIL rnd_head cyc=%0d got=%b/%h exp=%b/%h", i, bus.irsprerr_o, bus.irspdata_o, exp_rerr(), exp_data()); end
            tick();
        end
        ldvalid = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'(i * 4), 2'd3, 1'b0, 1'b1);
            @(negedge clk);
            tick();
        end
        drive(1'b0, 32'd0, 2'd3, 1'b0, 1'b1);
        checks++; if (bus.irspvalid_o !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got=%b exp=1", bus.irspvalid_o); end
        #2;
        resetb = 1'b0;
        #1;
        checks++; if (bus.irspvalid_o !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", bus.irspvalid_o); end
        checks++; if (bus.ireqready_o !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b exp=1", bus.ireqready_o); end
        checks++; if ({bus.irsprerr_o, bus.irspdata_o} !== 33'd0) begin errors++; $display("FAIL arst_head got=%b/%h exp=0/0", bus.irsprerr_o, bus.irspdata_o); end
        q.delete();
        hold_d = '0;
        hold_e = 1'b0;
        @(posedge clk);
        #1;
        resetb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'd0, 2'd3, 1'b1, 1'b1);
            @(negedge clk);
            checks++; if (bus.irspvalid_o !== exp_valid()) begin errors++; $display("FAIL arst_stale cyc=%0d got=%b exp=%b", i, bus.irspvalid_o, exp_valid()); end
            checks++; if (bus.ireqready_o !== exp_ready()) begin errors++; $display("FAIL arst_ready_after cyc=%0d got=%b exp=%b", i, bus.ireqready_o, exp_ready()); end
            tick();
        end
    endtask

`ifdef MERLIN_IMEM_PRIV_CHECK_EN
    task automatic test_priv();
        logic        vt [4];
        logic [1:0]  ht [4];
        ldvalid = 1'b1; ldaddr = MEM_X'(32'h40); lddata = 32'hCAFE_0013;
        @(negedge clk);
        tick();
        ldvalid = 1'b0;
        vt = '{1'b1, 1'b1, 1'b0, 1'b0};
        ht = '{2'd0, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 4; i++) begin
            drive(vt[i], 32'h0000_0100, ht[i], 1'b1, 1'b1);
            @(negedge clk);
            checks++; if ({bus.irsprerr_o, bus.irspdata_o} !== {exp_rerr(), exp_data()}) begin errors++; $display("FAIL priv_head cyc=%0d got=%b/%h exp=%b/%h", i, bus.irsprerr_o, bus.irspdata_o, exp_rerr(), exp_data()); end
            if (i == 1) begin checks++; if ({bus.irspvalid_o, bus.irsprerr_o, bus.irspdata_o} !== {1'b1, 1'b1, 32'd0}) begin errors++; $display("FAIL priv_user got=%b/%b/%h exp=1/1/0", bus.irspvalid_o, bus.irsprerr_o, bus.irspdata_o); end end
            if (i == 2) begin checks++; if ({bus.irspvalid_o, bus.irsprerr_o, bus.irspdata_o} !== {1'b1, 1'b0, 32'hCAFE_0013}) begin errors++; $display("FAIL priv_mach got=%b/%b/%h exp=1/0/cafe0013", bus.irspvalid_o, bus.irsprerr_o, bus.irspdata_o); end end
            tick();
        end
    endtask
`endif

    initial begin
        drive(1'b0, 32'd0, 2'd3, 1'b0, 1'b1);
        test_reset();
        test_fill();
        test_basic();
        test_backpressure();
        test_simultaneous();
        test_range();
`ifdef MERLIN_IMEM_PRIV_CHECK_EN
        test_priv();
`endif
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
